// File: rtl/rv_word_splitter_if.sv
// ----------------------------------------------------------------------------
// rv_word_splitter_if
// Ready/valid bundle around the word splitter.
//   input_port_*  : word-wide upstream channel (data, count, last, valid, ready)
//   output_port_* : byte-wide downstream channel (data, last, valid, ready)
// Modports:
//   slave  : the splitter's view (consumes words, produces bytes)
//   master : the environment's view (produces words, consumes bytes)
// ----------------------------------------------------------------------------
interface rv_word_splitter_if #(
    parameter int BYTES = 4
) ();
    localparam int CW = $clog2(BYTES);

    logic [8*BYTES-1:0] input_port_data;
    logic [CW-1:0]      input_port_count;
    logic               input_port_last;
    logic               input_port_valid;
    logic               input_port_ready;

    logic [7:0]         output_port_data;
    logic               output_port_last;
    logic               output_port_valid;
    logic               output_port_ready;

    modport slave (
        input  input_port_data,
        input  input_port_count,
        input  input_port_last,
        input  input_port_valid,
        output input_port_ready,
        output output_port_data,
        output output_port_last,
        output output_port_valid,
        input  output_port_ready
    );

    modport master (
        output input_port_data,
        output input_port_count,
        output input_port_last,
        output input_port_valid,
        input  input_port_ready,
        input  output_port_data,
        input  output_port_last,
        input  output_port_valid,
        output output_port_ready
    );
endinterface

// File: rtl/rv_word_splitter.sv
// ----------------------------------------------------------------------------
// rv_word_splitter
// Ready/valid width down-converter: accepts BYTES-byte words tagged with a
// byte count (valid bytes minus one) and an end-of-packet flag, and emits the
// valid bytes one per cycle, least-significant first. The next word is
// accepted on the edge that drains the final byte, so back-to-back words run
// at full byte rate.
// Ports:
//   clock_port : clock, rising edge
//   reset_port : asynchronous active-low reset
//   bus        : rv_word_splitter_if.slave (word input, byte output)
// Byte outputs come straight from registers; input_port_ready is the only
// combinational input-to-output path (through output_port_ready).
// ----------------------------------------------------------------------------
module rv_word_splitter #(
    parameter int BYTES = 4
) (
    input  logic              clock_port,
    input  logic              reset_port,
    rv_word_splitter_if.slave bus
);
    localparam int CW = $clog2(BYTES);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                 state_r, state_s;
    logic [BYTES-1:0][7:0]  word_r,  word_s;
    logic [CW-1:0]          cnt_r,   cnt_s;
    logic [CW-1:0]          idx_r,   idx_s;
    logic                   last_r,  last_s;

    logic busy_s;
    logic final_s;
    logic out_xfer_s;
    logic in_ready_s;
    logic in_xfer_s;

    assign busy_s     = (state_r == ST_BUSY);
    assign final_s    = busy_s & (idx_r == cnt_r);
    assign out_xfer_s = busy_s & bus.output_port_ready;
    // Ready is held low during reset, and also covers the drain-and-reload
    // case where the final byte leaves on the same edge the next word lands.
    assign in_ready_s = reset_port & (~busy_s | (final_s & bus.output_port_ready));
    assign in_xfer_s  = bus.input_port_valid & in_ready_s;

    // Next-state logic: a word load wins over any drain/advance in the same cycle.
    always_comb begin
        state_s = state_r;
        word_s  = word_r;
        cnt_s   = cnt_r;
        idx_s   = idx_r;
        last_s  = last_r;
        if (in_xfer_s) begin
            state_s = ST_BUSY;
            word_s  = bus.input_port_data;
            cnt_s   = bus.input_port_count;
            last_s  = bus.input_port_last;
            idx_s   = {CW{1'b0}};
        end else if (out_xfer_s & final_s) begin
            // idx is left where it is; it is reloaded with the next word.
            state_s = ST_IDLE;
        end else if (out_xfer_s) begin
            // Cannot wrap: idx stays at or below cnt, which is at most BYTES-1.
            idx_s = idx_r + CW'(1);
        end else begin
            state_s = state_r;
        end
    end

    // State registers with asynchronous clear that discards any held word.
    always_ff @(posedge clock_port or negedge reset_port) begin
        if (!reset_port) begin
            state_r <= ST_IDLE;
            word_r  <= '0;
            cnt_r   <= {CW{1'b0}};
            idx_r   <= {CW{1'b0}};
            last_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            word_r  <= word_s;
            cnt_r   <= cnt_s;
            idx_r   <= idx_s;
            last_r  <= last_s;
        end
    end

    assign bus.output_port_valid = busy_s;
    assign bus.output_port_data  = word_r[idx_r];
    assign bus.output_port_last  = final_s & last_r;
    assign bus.input_port_ready  = in_ready_s;
endmodule

// File: tb/tb_rv_word_splitter.sv
// ----------------------------------------------------------------------------
// tb_rv_word_splitter
// Directed and randomised stimulus for rv_word_splitter (BYTES = 4). A
// reference queue receives the valid bytes of every accepted word; a monitor
// compares each transferred byte against it and checks stall stability. A
// byte log lets the directed tests pin exact literal sequences.
// ----------------------------------------------------------------------------
module tb_rv_word_splitter;
    localparam int BYTES = 4;

    typedef struct {
        logic [7:0] d;
        logic       l;
        int         cyc;
    } ent_t;

    logic clk;
    logic rst_n;

    rv_word_splitter_if #(.BYTES(BYTES)) bus ();

    rv_word_splitter #(.BYTES(BYTES)) dut (
        .clock_port (clk),
        .reset_port (rst_n),
        .bus        (bus.slave)
    );

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    ent_t exp_q[$];
    ent_t log_q[$];
    logic prev_hold = 1'b0;
    logic [7:0] prev_d;
    logic prev_l;
    logic stop_stall;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: samples mid-cycle, after inputs settle and before the next edge.
    always @(negedge clk) begin
        ent_t e;
        logic [31:0] w;
        int c;
        #2;
        cyc++;
        if (rst_n) begin
            if (prev_hold) begin
                chk("stall_valid", {31'd0, bus.output_port_valid}, 32'd1);
                chk("stall_data", {24'd0, bus.output_port_data}, {24'd0, prev_d});
                chk("stall_last", {31'd0, bus.output_port_last}, {31'd0, prev_l});
            end
            if (bus.input_port_valid && bus.input_port_ready) begin
                w = bus.input_port_data;
                c = int'(bus.input_port_count);
                for (int k = 0; k <= c; k++) begin
                    e.d   = w[8*k +: 8];
                    e.l   = bus.input_port_last && (k == c);
                    e.cyc = 0;
                    exp_q.push_back(e);
                end
            end
            if (bus.output_port_valid) begin
                chk("valid_has_pending", {31'd0, exp_q.size() != 0}, 32'd1);
                if (bus.output_port_ready && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("byte_data", {24'd0, bus.output_port_data}, {24'd0, e.d});
                    chk("byte_last", {31'd0, bus.output_port_last}, {31'd0, e.l});
                    e.d   = bus.output_port_data;
                    e.l   = bus.output_port_last;
                    e.cyc = cyc;
                    log_q.push_back(e);
                end
            end
            prev_hold = bus.output_port_valid && !bus.output_port_ready;
            prev_d    = bus.output_port_data;
            prev_l    = bus.output_port_last;
        end else begin
            prev_hold = 1'b0;
        end
    end

    // Offer one word starting at a falling edge; returns at the falling edge
    // after acceptance. acc captures {valid, data} on the output at accept time.
    task automatic send(input logic [31:0] d, input logic [1:0] c, input logic l,
                        output logic [8:0] acc);
        int n = 0;
        bus.input_port_data  = d;
        bus.input_port_count = c;
        bus.input_port_last  = l;
        bus.input_port_valid = 1'b1;
        #1;
        while (!bus.input_port_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("send_accepted", {31'd0, n < 200}, 32'd1);
        acc = {bus.output_port_valid, bus.output_port_data};
        @(negedge clk);
        bus.input_port_valid = 1'b0;
    endtask

    // Run with ready high until the reference queue is empty and valid drops.
    task automatic drain();
        int n = 0;
        bus.output_port_ready = 1'b1;
        while (n < 100) begin
            @(negedge clk);
            #3;
            if (exp_q.size() == 0 && !bus.output_port_valid) break;
            n++;
        end
        chk("drain_done", {31'd0, n < 100}, 32'd1);
        @(negedge clk);
    endtask

    // Compare the byte log with a literal sequence (bytes LSB first, one last bit per byte).
    task automatic check_log(input int n, input logic [63:0] bytes, input logic [7:0] lasts);
        chk("log_len", log_q.size(), n);
        for (int i = 0; i < n && i < log_q.size(); i++) begin
            chk("log_data", {24'd0, log_q[i].d}, {24'd0, bytes[8*i +: 8]});
            chk("log_last", {31'd0, log_q[i].l}, {31'd0, lasts[i]});
        end
    endtask

    initial begin
        logic [8:0] acc;
        logic [31:0] rd;
        logic [1:0]  rc;
        logic        rl;
        int          idle;

        // Reset held with a word offered.
        rst_n                 = 1'b0;
        bus.input_port_data   = 32'h0;
        bus.input_port_count  = 2'd0;
        bus.input_port_last   = 1'b0;
        bus.input_port_valid  = 1'b1;
        bus.output_port_ready = 1'b1;
        stop_stall            = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready", {31'd0, bus.input_port_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, bus.output_port_valid}, 32'd0);
        chk("rst_out_data", {24'd0, bus.output_port_data}, 32'h00);
        chk("rst_out_last", {31'd0, bus.output_port_last}, 32'd0);
        @(negedge clk);
        rst_n                = 1'b1;
        bus.input_port_valid = 1'b0;
        #1;
        chk("rel_in_ready", {31'd0, bus.input_port_ready}, 32'd1);
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("idle_no_byte", {31'd0, bus.output_port_valid}, 32'd0);
        end
        @(negedge clk);

        // Two full words back to back.
        log_q.delete();
        send(32'h44332211, 2'd3, 1'b0, acc);
        chk("w1_accept_idle", {31'd0, acc[8]}, 32'd0);
        send(32'h88776655, 2'd3, 1'b1, acc);
        chk("w2_accept_on_44", {23'd0, acc}, {23'd0, 9'h144});
        drain();
        check_log(8, 64'h8877665544332211, 8'h80);
        for (int i = 1; i < 8 && i < log_q.size(); i++)
            chk("no_bubble", log_q[i].cyc - log_q[i-1].cyc, 32'd1);

        // Partial words.
        log_q.delete();
        send(32'hDEADBEEF, 2'd1, 1'b1, acc);
        drain();
        check_log(2, 64'hBEEF, 8'h02);
        log_q.delete();
        send(32'hDEADBEEF, 2'd0, 1'b1, acc);
        drain();
        check_log(1, 64'hEF, 8'h01);

        // Backpressure while byte 0x22 is presented.
        log_q.delete();
        send(32'h44332211, 2'd3, 1'b1, acc);
        @(negedge clk);
        bus.output_port_ready = 1'b0;
        repeat (5) begin
            #1;
            chk("bp_data", {24'd0, bus.output_port_data}, 32'h22);
            chk("bp_valid", {31'd0, bus.output_port_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, bus.input_port_ready}, 32'd0);
            @(negedge clk);
        end
        drain();
        check_log(4, 64'h44332211, 8'h08);

        // Reset after byte 0x22 has been taken.
        log_q.delete();
        send(32'h44332211, 2'd3, 1'b0, acc);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_valid", {31'd0, bus.output_port_valid}, 32'd0);
        chk("mid_rst_data", {24'd0, bus.output_port_data}, 32'h00);
        chk("mid_rst_in_ready", {31'd0, bus.input_port_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_rel_in_ready", {31'd0, bus.input_port_ready}, 32'd1);
        @(negedge clk);
        log_q.delete();
        send(32'h000000AA, 2'd0, 1'b1, acc);
        drain();
        check_log(1, 64'hAA, 8'h01);

        // Random stalls on both sides over 1000 words.
        fork
            begin
                while (!stop_stall) begin
                    bus.output_port_ready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
            end
            begin
                for (int w = 0; w < 1000; w++) begin
                    idle = 0;
                    while ($urandom_range(0, 1) == 1 && idle < 8) begin
                        @(negedge clk);
                        idle++;
                    end
                    rd = $urandom;
                    rc = 2'($urandom_range(0, 3));
                    rl = 1'($urandom_range(0, 1));
                    send(rd, rc, rl, acc);
                end
                stop_stall = 1'b1;
            end
        join
        drain();
        chk("ref_queue_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rv_word_splitter.md
# rv_word_splitter

Ready/valid width down-converter. Accepts words of `BYTES` bytes, each tagged with a byte count and an end-of-packet flag, and emits them one byte per cycle, least-significant byte first. Sits directly upstream of the 8-bit forward buffer stage and drives its input port. Sustains full byte-rate throughput with no bubbles between consecutive words.

## Interface

Parameters:
- `BYTES`, default 4: bytes per input word. Power of two, ≥ 2.
- `CW`, derived as $clog2(`BYTES`): width of the count field.

Ports:
- `clock_port` in 1: single clock. All state updates on the rising edge.
- `reset_port` in 1: reset, asynchronous, active-low.
- `input_port_data` in 8*`BYTES`: word. Byte k is bits [8k+7:8k].
- `input_port_count` in `CW`: number of valid bytes minus 1 (0 means 1 byte, `BYTES`-1 means full word). Valid bytes are 0..count.
- `input_port_last` in 1: the word ends a packet.
- `input_port_valid` in 1: word offered.
- `input_port_ready` out 1: word accepted when valid & ready at a clock edge.
- `output_port_data` out 8: current byte.
- `output_port_last` out 1: this byte is the final byte of a packet.
- `output_port_valid` out 1: byte offered.
- `output_port_ready` in 1: downstream accepts the byte when valid & ready.

## Operation

- State:
  - `word_reg` (8*`BYTES`): holds the accepted word.
  - `cnt_reg` (`CW`): holds the accepted count.
  - `last_reg`: holds the accepted last flag.
  - `idx` (`CW`): index of the current byte.
  - `busy`: a word is held.
- Derived signals:
  - `final = busy & (idx == cnt_reg)`
  - `out_xfer = busy & output_port_ready`
  - `in_xfer = input_port_valid & input_port_ready`
- Outputs:
  - `output_port_valid = busy`
  - `output_port_data = word_reg[8*idx +: 8]`
  - `output_port_last = final & last_reg`
  - `input_port_ready = reset_port & (~busy | (final & output_port_ready))`
- On `in_xfer`:
  - Load `word_reg`, `cnt_reg` and `last_reg` from the inputs.
  - Set `idx` = 0 and `busy` = 1.
  - This takes priority over all other updates in the same cycle. It covers the simultaneous final-byte drain and new-word load.
- Else if `out_xfer & final`: `busy` = 0. `idx` holds its value (don't-care).
- Else if `out_xfer`: `idx` = `idx` + 1. It never wraps, because `idx` ≤ `cnt_reg` ≤ `BYTES`-1.
- Otherwise all state holds.
- Output valid stays asserted and data stays stable while `output_port_ready` is low. Nothing is dropped or reordered.
- Bytes above `input_port_count` are ignored and never emitted.
- A word with `input_port_last` = 0 never produces `output_port_last` = 1.
- Count 0 yields exactly one byte, which also carries the last flag when applicable.

## Timing

- Reset (`reset_port` low), asynchronous:
  - `busy` = 0, `idx` = 0, `word_reg` = 0, `cnt_reg` = 0, `last_reg` = 0.
  - `output_port_valid` = 0, `output_port_data` = 0x00, `output_port_last` = 0.
  - `input_port_ready` = 0 for as long as reset is held.
- Reset mid-word: the held word is discarded immediately, with no partial-byte completion. After release, `input_port_ready` = 1 in the same cycle.
- Latency: a word accepted at edge N presents byte 0 from edge N onward, so it is visible in cycle N+1. There is no combinational path from `input_port_data` to `output_port_data`.
- Throughput: a word with count c occupies c+1 output cycles when `output_port_ready` is held high. The next word is accepted on the final-byte edge, so there are zero idle cycles between words.
- `input_port_ready` depends combinationally on `output_port_ready`. This path is the only input-to-output combinational path and is acceptable, because the forward buffer stage registers its own ready.
- `output_port_valid`, `output_port_data` and `output_port_last` are pure functions of registers.

## Test plan

- **Reset:** hold `reset_port` low with `input_port_valid` = 1 → `input_port_ready` = 0, `output_port_valid` = 0. Release → ready = 1, no byte emitted before the first accept.
- **Full word, back-to-back:** `BYTES` = 4, `output_port_ready` held 1.
  - Stimulus: words 0x44332211 (count 3, last 0) then 0x88776655 (count 3, last 1).
  - Required: 11 22 33 44 55 66 77 88 on 8 consecutive cycles; `output_port_last` = 1 only on 0x88; `input_port_ready` pulses high on the 0x44 cycle.
- **Partial words:**
  - 0xDEADBEEF with count 1, last 1 → EF, BE; last on BE; 0xDE and 0xAD never appear.
  - Count 0, last 1 → single byte EF with last = 1.
- **Backpressure:** `output_port_ready` = 0 for 5 cycles while holding byte 0x22 → data stays 0x22 and valid stays 1 throughout; `input_port_ready` = 0. Then the sequence resumes with 0x33.
- **Random stall:** random `input_port_valid` and `output_port_ready` (50%) over 1000 words with random counts → output byte stream and last flags match a reference queue exactly.
- **Reset mid-word:** assert reset after byte 0x22 of 0x44332211 → valid drops asynchronously. After release and a new word 0x000000AA (count 0) → only AA is emitted.
